load_store_unit: RTL and testbench

- Memory-stage block downstream of the main decoder.
- Consumes the decoded MemWrite, load-select, MemSize and load-sign controls, plus the ALU address and store data.
- Performs one byte, half-word or word access on the SoC data bus using a req/gnt/rvalid handshake.
- Formats load data and stalls the pipeline until the access completes.

---
 rtl/load_store_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-stage load/store unit. Issues one byte/half/word access
//               on a req/gnt/rvalid data bus, formats load data and stalls the
//               pipeline until the access completes. Misaligned accesses are
//               flagged without bus traffic.
//               Optional macro LSU_TIMEOUT_EN: abort REQ/RESP after
//               TIMEOUT_CYCLES cycles and pulse BusErrM.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [1:0]        MemSizeM,
    input  logic              LoadUnsignedM,
    input  logic [ADDR_W-1:0] AddrM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              StallLSU,
    output logic              MisalignM,
    output logic              BusErrM,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              w_access;
    logic              w_is_byte;
    logic              w_is_half;
    logic              w_misalign;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_shift;
    logic [31:0]       w_load;
    logic              w_timeout;

    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_off;
    logic              r_byte;
    logic              r_half;
    logic              r_uns;
    logic              r_we;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_misalign;

    // Decode the incoming request: size, alignment, lane enables and store data
    always_comb begin
        w_access  = MemReadM | MemWriteM;
        w_is_byte = (MemSizeM == 2'b01);
        w_is_half = (MemSizeM == 2'b10);
        // Size 00 falls into the word case together with 11
        w_misalign = (w_is_half & AddrM[0]) |
                     (~w_is_byte & ~w_is_half & (AddrM[1:0] != 2'b00));
        if (w_is_byte) begin
            w_be    = 4'b0001 << AddrM[1:0];
            w_wdata = {4{WriteDataM[7:0]}};
        end else if (w_is_half) begin
            w_be    = 4'b0011 << {AddrM[1], 1'b0};
            w_wdata = {2{WriteDataM[15:0]}};
        end else begin
            w_be    = 4'b1111;
            w_wdata = WriteDataM;
        end
    end

    // Select the addressed lane of the read data and extend it to 32 bits
    always_comb begin
        w_shift = bus_rdata >> {r_off, 3'b000};
        if (r_byte) begin
            w_load = {{24{~r_uns & w_shift[7]}}, w_shift[7:0]};
        end else if (r_half) begin
            w_load = {{16{~r_uns & w_shift[15]}}, w_shift[15:0]};
        end else begin
            w_load = bus_rdata;
        end
    end

`ifdef LSU_TIMEOUT_EN
    localparam int c_TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TCNT_W-1:0] r_tcnt;
    logic                r_buserr;

    // Count cycles spent waiting on the bus; cleared whenever not waiting
    always_ff @(posedge clk) begin
        if (rst || !((r_state == REQ) || (r_state == RESP))) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // Timeout fires on the TIMEOUT_CYCLES-th waiting cycle
    always_comb begin
        w_timeout = ((r_state == REQ) || (r_state == RESP)) &&
                    (r_tcnt == c_TCNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Bus error flag is high only during the DONE cycle of an aborted access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buserr <= 1'b0;
        end else begin
            r_buserr <= ((r_state == REQ)  && !bus_gnt    && w_timeout) ||
                        ((r_state == RESP) && !bus_rvalid && w_timeout);
        end
    end

    assign BusErrM = r_buserr;
`else
    assign w_timeout = 1'b0;
    assign BusErrM   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a completing handshake wins over a coincident timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_next = w_misalign ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    w_next = r_we ? DONE : RESP;
                end else if (w_timeout) begin
                    w_next = DONE;
                end
            end
            RESP: begin
                if (bus_rvalid || w_timeout) begin
                    w_next = DONE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Capture request fields on issue and the formatted result on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_off      <= 2'b00;
            r_byte     <= 1'b0;
            r_half     <= 1'b0;
            r_uns      <= 1'b0;
            r_we       <= 1'b0;
            r_be       <= 4'b0000;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_access && w_misalign) begin
                        r_rdata    <= 32'h0;
                        r_misalign <= 1'b1;
                    end else if (w_access) begin
                        r_addr  <= {AddrM[ADDR_W-1:2], 2'b00};
                        r_off   <= AddrM[1:0];
                        r_byte  <= w_is_byte;
                        r_half  <= w_is_half;
                        r_uns   <= LoadUnsignedM;
                        r_we    <= MemWriteM;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                    end
                end
                REQ: begin
                    if (!bus_gnt && w_timeout) begin
                        r_rdata <= 32'h0;
                    end
                end
                RESP: begin
                    if (bus_rvalid) begin
                        r_rdata <= w_load;
                    end else if (w_timeout) begin
                        r_rdata <= 32'h0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign StallLSU  = ((r_state == IDLE) && w_access) ||
                       (r_state == REQ) || (r_state == RESP);
    assign bus_req   = (r_state == REQ);
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;
    assign ReadDataM = r_rdata;
    assign MisalignM = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit: directed vector table,
//               randomized accesses against a byte-level reference model, and
//               hand-written reset / timeout sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [1:0]  MemSizeM = 2'b00;
    logic        LoadUnsignedM = 1'b0;
    logic [31:0] AddrM = 32'h0;
    logic [31:0] WriteDataM = 32'h0;
    logic [31:0] ReadDataM;
    logic        StallLSU;
    logic        MisalignM;
    logic        BusErrM;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
        .LoadUnsignedM(LoadUnsignedM), .AddrM(AddrM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .StallLSU(StallLSU), .MisalignM(MisalignM),
        .BusErrM(BusErrM), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
    endfunction

    function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be = 4'b0000;
        int n  = nbytes(sz);
        int lo = int'(a % 4);
        for (int i = 0; i < 4; i++) be[i] = (i >= lo) && (i < lo + n);
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n = nbytes(sz);
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes(sz);
        longint span = longint'(1) << (8 * n);
        longint v = (longint'(rd) >> (8 * (a % 4))) % span;
        if (!uns && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // ---------------- bus-side driver / observer ----------------
    int          o_stall, o_req;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_be;
    logic        o_we, o_mis, o_err, o_stable, o_spur, o_bound;

    // Called at a falling edge; returns at the falling edge after DONE.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdata, input int gdly, input int rvdly,
                             input bit spur);
        int rv_cnt = -1;
        int cyc = 0;
        bit fin = 0;
        MemReadM = rd; MemWriteM = wr; MemSizeM = sz; LoadUnsignedM = uns;
        AddrM = a; WriteDataM = wd;
        o_stall = 0; o_req = 0; o_stable = 1; o_spur = 0; o_bound = 0;
        o_mis = 0; o_err = 0; o_rdata = 0;
        o_addr = 0; o_wdata = 0; o_be = 0; o_we = 0;
        while (!fin) begin
            bus_gnt = 0; bus_rvalid = 0;
            if (rv_cnt == 0) begin
                bus_rvalid = 1; bus_rdata = rdata;
            end else if (spur && rv_cnt < 0) begin
                bus_rvalid = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
            end
            #1;
            if (bus_req) begin
                if (o_req == 0) begin
                    o_addr = bus_addr; o_be = bus_be; o_wdata = bus_wdata; o_we = bus_we;
                end else if (bus_addr !== o_addr || bus_be !== o_be ||
                             bus_wdata !== o_wdata || bus_we !== o_we) begin
                    o_stable = 0;
                end
                if (o_req == gdly) begin
                    bus_gnt = 1;
                    if (!bus_we) rv_cnt = rvdly;
                end
                o_req++;
            end
            if (!StallLSU) begin
                fin = 1; o_mis = MisalignM; o_rdata = ReadDataM; o_err = BusErrM;
            end else begin
                o_stall++;
                if (MisalignM || BusErrM) o_spur = 1;
            end
            cyc++;
            if (cyc > 60) begin
                fin = 1; o_bound = 1;
            end
            @(posedge clk);
            if (rv_cnt >= 0) rv_cnt--;
            @(negedge clk);
        end
        bus_gnt = 0; bus_rvalid = 0; MemReadM = 0; MemWriteM = 0;
    endtask

    task automatic check_obs(input string tag, input logic exp_mis, input int exp_stall,
                             input logic [31:0] a, input logic [3:0] exp_be,
                             input logic [31:0] exp_wd, input logic exp_we,
                             input int exp_req, input bit chk_rd, input logic [31:0] exp_rd);
        chk({tag, "_bound"}, 32'(o_bound), 32'd0);
        chk({tag, "_stall"}, o_stall, exp_stall);
        chk({tag, "_req"},   o_req, exp_req);
        chk({tag, "_mis"},   32'(o_mis), 32'(exp_mis));
        chk({tag, "_err"},   32'(o_err), 32'd0);
        chk({tag, "_spur"},  32'(o_spur), 32'd0);
        if (exp_req > 0) begin
            chk({tag, "_addr"},   o_addr, {a[31:2], 2'b00});
            chk({tag, "_be"},     32'(o_be), 32'(exp_be));
            chk({tag, "_wdata"},  o_wdata, exp_wd);
            chk({tag, "_we"},     32'(o_we), 32'(exp_we));
            chk({tag, "_stable"}, 32'(o_stable), 32'd1);
        end
        if (chk_rd) chk({tag, "_rdata"}, o_rdata, exp_rd);
    endtask

    typedef struct {
        logic        rd, wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr, wd, rdata;
        int          gdly, rvdly;
        logic        mis;
        int          stall;
        logic [3:0]  be;
        logic [31:0] bwd, exp_rd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // rd wr sz uns addr wd rdata gdly rvdly | mis stall be bus_wdata readdata
        tbl[0] = '{0,1,2'b01,0,32'h1003,32'h000000A5,32'h0,0,1, 0,2,4'b1000,32'hA5A5A5A5,32'h0};
        tbl[1] = '{1,0,2'b10,0,32'h2002,32'h0,32'h80127FFF,0,1, 0,3,4'b1100,32'h0,32'hFFFF8012};
        tbl[2] = '{1,0,2'b10,1,32'h2002,32'h0,32'h80127FFF,0,1, 0,3,4'b1100,32'h0,32'h00008012};
        tbl[3] = '{1,0,2'b01,1,32'h0021,32'h0,32'h0000F300,0,1, 0,3,4'b0010,32'h0,32'h000000F3};
        tbl[4] = '{1,0,2'b11,0,32'h0040,32'h0,32'hDEADBEEF,0,1, 0,3,4'b1111,32'h0,32'hDEADBEEF};
        tbl[5] = '{1,0,2'b11,0,32'h3001,32'h0,32'h0,0,1,       1,1,4'b0000,32'h0,32'h0};
        tbl[6] = '{0,1,2'b11,0,32'h0500,32'h12345678,32'h0,3,1, 0,5,4'b1111,32'h12345678,32'h0};
        tbl[7] = '{1,0,2'b01,0,32'h0083,32'h0,32'h80000000,1,2, 0,5,4'b1000,32'h0,32'hFFFFFF80};
        tbl[8] = '{1,1,2'b10,0,32'h0602,32'h1234BEEF,32'h0,0,1, 0,2,4'b1100,32'hBEEFBEEF,32'h0};
        tbl[9] = '{0,1,2'b10,0,32'h0701,32'h1234BEEF,32'h0,0,1, 1,1,4'b0000,32'h0,32'h0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   32'(bus_req), 0);
        chk("rst_we",    32'(bus_we), 0);
        chk("rst_addr",  bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_be",    32'(bus_be), 0);
        chk("rst_rdata", ReadDataM, 0);
        chk("rst_mis",   32'(MisalignM), 0);
        chk("rst_err",   32'(BusErrM), 0);
        chk("rst_stall", 32'(StallLSU), 0);
        rst = 0;
        @(negedge clk);

        // Directed vectors, issued back-to-back
        for (int i = 0; i < 10; i++) begin
            do_access(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd,
                      tbl[i].rdata, tbl[i].gdly, tbl[i].rvdly, 0);
            check_obs($sformatf("vec%0d", i), tbl[i].mis, tbl[i].stall, tbl[i].addr,
                      tbl[i].be, tbl[i].bwd, tbl[i].wr,
                      tbl[i].mis ? 0 : tbl[i].gdly + 1,
                      (tbl[i].rd && !tbl[i].wr) || tbl[i].mis, tbl[i].exp_rd);
        end

        // Randomized accesses against the reference model
        for (int i = 0; i < 150; i++) begin
            int          kind  = $urandom_range(0, 2);
            logic        rd    = (kind != 1);
            logic        wr    = (kind != 0);
            logic [1:0]  sz    = 2'($urandom);
            logic        uns   = 1'($urandom);
            logic [31:0] a     = $urandom;
            logic [31:0] wd    = $urandom;
            logic [31:0] rdat  = $urandom;
            int          gdly  = $urandom_range(0, 3);
            int          rvdly = $urandom_range(1, 3);
            logic        mis;
            int          st;
            if ($urandom_range(0, 9) < 6) a = a & ~32'(nbytes(sz) - 1);
            mis = ref_mis(sz, a);
            st  = mis ? 1 : (wr ? 2 + gdly : 2 + gdly + rvdly);
            if (($urandom % 4) == 0) @(negedge clk);
            do_access(rd, wr, sz, uns, a, wd, rdat, gdly, rvdly, 1);
            check_obs($sformatf("rnd%0d", i), mis, st, a, ref_be(sz, a), ref_wdata(sz, wd),
                      wr, mis ? 0 : gdly + 1, (rd && !wr) || mis,
                      mis ? 32'h0 : ref_load(sz, uns, a, rdat));
        end

        // Reset while a load waits in RESP
        do_access(1, 0, 2'b11, 0, 32'h80, 0, 32'hCAFEF00D, 0, 1, 0);
        chk("pre_rdata", o_rdata, 32'hCAFEF00D);
        MemReadM = 1; MemSizeM = 2'b11; AddrM = 32'h84;
        @(posedge clk); @(negedge clk);
        bus_gnt = 1;
        @(posedge clk); @(negedge clk);
        bus_gnt = 0;
        #1;
        chk("resp_stall", 32'(StallLSU), 1);
        chk("resp_hold",  ReadDataM, 32'hCAFEF00D);
        rst = 1;
        @(posedge clk); @(negedge clk);
        rst = 0; MemReadM = 0;
        #1;
        chk("midrst_req",   32'(bus_req), 0);
        chk("midrst_rdata", ReadDataM, 0);
        chk("midrst_stall", 32'(StallLSU), 0);
        chk("midrst_addr",  bus_addr, 0);
        @(negedge clk);
        bus_rvalid = 1; bus_rdata = 32'h12345678;
        @(posedge clk); @(negedge clk);
        bus_rvalid = 0;
        chk("stray_rv", ReadDataM, 0);

`ifdef LSU_TIMEOUT_EN
        // Grant never arrives: abort after four REQ cycles
        do_access(1, 0, 2'b11, 0, 32'h100, 0, 32'h0, 1000, 1, 0);
        chk("to_bound", 32'(o_bound), 0);
        chk("to_stall", o_stall, 5);
        chk("to_req",   o_req, 4);
        chk("to_err",   32'(o_err), 1);
        chk("to_rdata", o_rdata, 0);
        chk("to_spur",  32'(o_spur), 0);
        #1;
        chk("to_req_after", 32'(bus_req), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
